// File: rtl/branch_predictor_ctrl_if.sv
// Fetch/decode-side signal bundle for branch_predictor_ctrl.
// master: pipeline side (drives PCs and resolved outcomes).
// slave : predictor side (returns prediction, mispredict and redirect PC).
interface branch_predictor_ctrl_if;
   logic        en;
   logic [15:0] IF_PC_curr;
   logic        IF_pred_taken;
   logic [15:0] IF_pred_target;
   logic        ID_valid;
   logic        ID_is_branch;
   logic [15:0] ID_PC_curr;
   logic [15:0] ID_PC_next;
   logic        ID_pred_taken;
   logic [15:0] ID_pred_target;
   logic        ID_actual_taken;
   logic [15:0] ID_actual_target;
   logic        mispredicted;
   logic [15:0] PC_redirect;

   modport master (
      output en, IF_PC_curr, ID_valid, ID_is_branch, ID_PC_curr, ID_PC_next,
             ID_pred_taken, ID_pred_target, ID_actual_taken, ID_actual_target,
      input  IF_pred_taken, IF_pred_target, mispredicted, PC_redirect
   );

   modport slave (
      input  en, IF_PC_curr, ID_valid, ID_is_branch, ID_PC_curr, ID_PC_next,
             ID_pred_taken, ID_pred_target, ID_actual_taken, ID_actual_target,
      output IF_pred_taken, IF_pred_target, mispredicted, PC_redirect
   );
endinterface

// File: rtl/branch_predictor_ctrl.sv
// Dynamic branch predictor and fetch-redirect controller.
// Direct-mapped BTB with 2-bit saturating counters, combinational lookup
// at fetch, resolution and table update from the decode stage.
// Optional feature macro: BP_PERF_CNT_EN (adds br_count / mispred_count).
module branch_predictor_ctrl #(
   parameter int unsigned INDEX_BITS = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   branch_predictor_ctrl_if.slave bp
`ifdef BP_PERF_CNT_EN
   ,
   output logic [15:0]            br_count,
   output logic [15:0]            mispred_count
`endif
);

   localparam int unsigned ENTRIES  = 1 << INDEX_BITS;
   localparam int unsigned TAG_BITS = 15 - INDEX_BITS;

   logic                valid_q  [ENTRIES];
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [15:0]         target_q [ENTRIES];
   logic [1:0]          ctr_q    [ENTRIES];

   logic [INDEX_BITS-1:0] if_idx;
   logic [TAG_BITS-1:0]   if_tag;
   logic [INDEX_BITS-1:0] id_idx;
   logic [TAG_BITS-1:0]   id_tag;
   logic                  if_hit;
   logic                  if_pred;
   logic                  id_hit;
   logic                  upd;
   logic                  mis_raw;
   logic [15:0]           redirect_raw;
   logic                  unused_pc_lsb;

   // PC bit 0 is always zero for 16-bit aligned instructions
   assign unused_pc_lsb = ^{bp.IF_PC_curr[0], bp.ID_PC_curr[0]};

   // Split fetch and decode PCs into table index and tag
   always_comb begin
      if_idx = bp.IF_PC_curr[INDEX_BITS:1];
      if_tag = bp.IF_PC_curr[15:INDEX_BITS+1];
      id_idx = bp.ID_PC_curr[INDEX_BITS:1];
      id_tag = bp.ID_PC_curr[15:INDEX_BITS+1];
   end

   // Fetch lookup: reads pre-update contents, so same-cycle writes appear next cycle
   always_comb begin
      if_hit             = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
      if_pred            = if_hit && ctr_q[if_idx][1];
      bp.IF_pred_taken   = !rst && if_pred;
      bp.IF_pred_target  = (!rst && if_pred) ? target_q[if_idx] : '0;
   end

   // Decode resolution: mispredict is independent of en so it holds across stalls
   always_comb begin
      upd          = bp.ID_valid && bp.ID_is_branch;
      id_hit       = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
      mis_raw      = upd && ((bp.ID_actual_taken != bp.ID_pred_taken) ||
                             (bp.ID_actual_taken && (bp.ID_actual_target != bp.ID_pred_target)));
      redirect_raw = bp.ID_actual_taken ? bp.ID_actual_target : bp.ID_PC_next;
      bp.mispredicted = !rst && mis_raw;
      bp.PC_redirect  = (!rst && mis_raw) ? redirect_raw : '0;
   end

   // Table update: train counters on hit, allocate only on a taken miss
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            valid_q[i[INDEX_BITS-1:0]]  <= 1'b0;
            tag_q[i[INDEX_BITS-1:0]]    <= '0;
            target_q[i[INDEX_BITS-1:0]] <= '0;
            ctr_q[i[INDEX_BITS-1:0]]    <= 2'b01;
         end
      end else if (upd && bp.en) begin
         if (id_hit) begin
            if (bp.ID_actual_taken) begin
               if (ctr_q[id_idx] != 2'b11) ctr_q[id_idx] <= ctr_q[id_idx] + 2'd1;
               target_q[id_idx] <= bp.ID_actual_target;
            end else if (ctr_q[id_idx] != 2'b00) begin
               ctr_q[id_idx] <= ctr_q[id_idx] - 2'd1;
            end
         end else if (bp.ID_actual_taken) begin
            valid_q[id_idx]  <= 1'b1;
            tag_q[id_idx]    <= id_tag;
            target_q[id_idx] <= bp.ID_actual_target;
            ctr_q[id_idx]    <= 2'b10;
         end
      end
   end

`ifdef BP_PERF_CNT_EN
   logic [15:0] br_cnt_q;
   logic [15:0] mis_cnt_q;

   // Saturating branch and mispredict counters
   always_ff @(posedge clk) begin
      if (rst) begin
         br_cnt_q  <= '0;
         mis_cnt_q <= '0;
      end else if (upd && bp.en) begin
         if (br_cnt_q != '1) br_cnt_q <= br_cnt_q + 16'd1;
         if (mis_raw && (mis_cnt_q != '1)) mis_cnt_q <= mis_cnt_q + 16'd1;
      end
   end

   // Counter outputs held at zero during reset
   always_comb begin
      br_count      = rst ? '0 : br_cnt_q;
      mispred_count = rst ? '0 : mis_cnt_q;
   end
`endif

endmodule
